// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family.
//   cnt_w(depth) : width of an occupancy count that can hold 0..depth
//   ptr_w(depth) : width of a read/write pointer covering 0..depth-1 (min 1)
//   WIDTH_DEF / DEPTH_DEF : default geometry
//   rd_mode_e    : STD (registered read) or FWFT (first-word-fall-through)
package fifo_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } rd_mode_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH storage array for the FIFO.
//   clk   : write clock
//   we    : write enable
//   waddr : write address (0..DEPTH-1)
//   wdata : write data
//   raddr : read address (0..DEPTH-1)
//   rdata : combinational read data at raddr
module fifo_regfile #(
  parameter int WIDTH = fifo_pkg::WIDTH_DEF,
  parameter int DEPTH = fifo_pkg::DEPTH_DEF
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [fifo_pkg::ptr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]                    wdata,
  input  logic [fifo_pkg::ptr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]                    rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost flags,
// synchronous flush and optional first-word-fall-through read.
//   clk          : clock, all logic on rising edge
//   clear_n      : asynchronous active-low reset
//   flush        : synchronous clear of pointers/count/flags (dout holds)
//   din/wr_en    : write data / write request
//   rd_en        : read request (pop in FWFT mode)
//   dout         : read data
//   full/almost_full/empty/almost_empty : registered from next count
//   count        : occupancy 0..DEPTH
//   wr_ack/wr_err/rd_ack/rd_err : outcome of the request at the previous edge
module sync_fifo_param #(
  parameter int WIDTH     = fifo_pkg::WIDTH_DEF,
  parameter int DEPTH     = fifo_pkg::DEPTH_DEF,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1,
  parameter int FWFT      = 0
) (
  input  logic                                clk,
  input  logic                                clear_n,
  input  logic                                flush,
  input  logic [WIDTH-1:0]                    din,
  input  logic                                wr_en,
  input  logic                                rd_en,
  output logic [WIDTH-1:0]                    dout,
  output logic                                full,
  output logic                                almost_full,
  output logic                                empty,
  output logic                                almost_empty,
  output logic [fifo_pkg::cnt_w(DEPTH)-1:0]   count,
  output logic                                wr_ack,
  output logic                                wr_err,
  output logic                                rd_ack,
  output logic                                rd_err
);

  import fifo_pkg::*;

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam rd_mode_e RD_MODE = (FWFT != 0) ? fifo_pkg::FWFT : STD;

  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt_next;
  logic             wr_accept, rd_accept;
  logic [WIDTH-1:0] rd_data;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full FIFO may still take a write when a read frees a slot on the same
  // edge; an empty FIFO never bypasses a write to the read side.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  always_comb begin
    cnt_next = count;
    if (flush) begin
      cnt_next = '0;
    end else if (wr_accept && !rd_accept) begin
      cnt_next = count + CW'(1);
    end else if (rd_accept && !wr_accept) begin
      cnt_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      wr_ack       <= 1'b0;
      wr_err       <= 1'b0;
      rd_ack       <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      count        <= cnt_next;
      full         <= (cnt_next == CW'(DEPTH));
      almost_full  <= (cnt_next >= CW'(DEPTH - AF_MARGIN));
      empty        <= (cnt_next == '0);
      almost_empty <= (cnt_next <= CW'(AE_MARGIN));
      if (flush) begin
        wptr   <= '0;
        rptr   <= '0;
        wr_ack <= 1'b0;
        wr_err <= 1'b0;
        rd_ack <= 1'b0;
        rd_err <= 1'b0;
      end else begin
        if (wr_accept) wptr <= next_ptr(wptr);
        if (rd_accept) rptr <= next_ptr(rptr);
        wr_ack <= wr_accept;
        wr_err <= wr_en && !wr_accept;
        rd_ack <= rd_accept;
        rd_err <= rd_en && !rd_accept;
      end
    end
  end

  fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_accept && !flush),
    .waddr (wptr),
    .wdata (din),
    .raddr (rptr),
    .rdata (rd_data)
  );

  if (RD_MODE == STD) begin : g_std
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
        dout_q <= '0;
      end else if (!flush && rd_accept) begin
        dout_q <= rd_data;
      end
    end

    assign dout = dout_q;
  end else begin : g_fwft
    // Head of queue straight from the array; stale but stable when empty.
    assign dout = rd_data;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int NI = 3;
  // instance 0: 16 deep std, 1: 5 deep std, 2: 4 deep FWFT
  int P_DEPTH [NI] = '{16, 5, 4};
  int P_AF    [NI] = '{1, 2, 1};
  int P_AE    [NI] = '{1, 2, 1};
  int P_FW    [NI] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic       clear_n;
  logic       flush [NI];
  logic [7:0] din   [NI];
  logic       wr_en [NI];
  logic       rd_en [NI];
  logic [7:0] dout  [NI];
  logic       full  [NI];
  logic       afull [NI];
  logic       empty [NI];
  logic       aempty[NI];
  logic       wack  [NI];
  logic       werr  [NI];
  logic       rack  [NI];
  logic       rerr  [NI];
  logic [4:0] cnt0;
  logic [2:0] cnt1, cnt2;
  int         dcnt  [NI];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(0)) u0 (
    .clk(clk), .clear_n(clear_n), .flush(flush[0]), .din(din[0]), .wr_en(wr_en[0]),
    .rd_en(rd_en[0]), .dout(dout[0]), .full(full[0]), .almost_full(afull[0]),
    .empty(empty[0]), .almost_empty(aempty[0]), .count(cnt0), .wr_ack(wack[0]),
    .wr_err(werr[0]), .rd_ack(rack[0]), .rd_err(rerr[0]));

  sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_MARGIN(2), .AE_MARGIN(2), .FWFT(0)) u1 (
    .clk(clk), .clear_n(clear_n), .flush(flush[1]), .din(din[1]), .wr_en(wr_en[1]),
    .rd_en(rd_en[1]), .dout(dout[1]), .full(full[1]), .almost_full(afull[1]),
    .empty(empty[1]), .almost_empty(aempty[1]), .count(cnt1), .wr_ack(wack[1]),
    .wr_err(werr[1]), .rd_ack(rack[1]), .rd_err(rerr[1]));

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(1)) u2 (
    .clk(clk), .clear_n(clear_n), .flush(flush[2]), .din(din[2]), .wr_en(wr_en[2]),
    .rd_en(rd_en[2]), .dout(dout[2]), .full(full[2]), .almost_full(afull[2]),
    .empty(empty[2]), .almost_empty(aempty[2]), .count(cnt2), .wr_ack(wack[2]),
    .wr_err(werr[2]), .rd_ack(rack[2]), .rd_err(rerr[2]));

  always_comb begin
    dcnt[0] = int'(cnt0);
    dcnt[1] = int'(cnt1);
    dcnt[2] = int'(cnt2);
  end

  // ---------------- behavioural model: a queue per instance ----------------
  logic [7:0] mq [NI][$];
  logic [7:0] m_dout [NI];
  bit m_wack [NI], m_werr [NI], m_rack [NI], m_rerr [NI];

  always @(posedge clk or negedge clear_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!clear_n) begin
        mq[i].delete();
        m_dout[i] = 8'h00;
        m_wack[i] = 0; m_werr[i] = 0; m_rack[i] = 0; m_rerr[i] = 0;
      end else if (flush[i]) begin
        mq[i].delete();
        m_wack[i] = 0; m_werr[i] = 0; m_rack[i] = 0; m_rerr[i] = 0;
      end else begin
        bit ra, wa;
        ra = rd_en[i] && (mq[i].size() > 0);
        wa = wr_en[i] && ((mq[i].size() < P_DEPTH[i]) || ra);
        if (ra) m_dout[i] = mq[i].pop_front();
        if (wa) mq[i].push_back(din[i]);
        m_wack[i] = wa;  m_werr[i] = wr_en[i] && !wa;
        m_rack[i] = ra;  m_rerr[i] = rd_en[i] && !ra;
      end
    end
  end

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[u%0d] got 0x%0h expected 0x%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        int n;
        n = mq[i].size();
        chk("count",        i, dcnt[i],         n);
        chk("empty",        i, int'(empty[i]),  int'(n == 0));
        chk("full",         i, int'(full[i]),   int'(n == P_DEPTH[i]));
        chk("almost_full",  i, int'(afull[i]),  int'(n >= P_DEPTH[i] - P_AF[i]));
        chk("almost_empty", i, int'(aempty[i]), int'(n <= P_AE[i]));
        chk("wr_ack",       i, int'(wack[i]),   int'(m_wack[i]));
        chk("wr_err",       i, int'(werr[i]),   int'(m_werr[i]));
        chk("rd_ack",       i, int'(rack[i]),   int'(m_rack[i]));
        chk("rd_err",       i, int'(rerr[i]),   int'(m_rerr[i]));
        if (P_FW[i] == 0)  chk("dout", i, int'(dout[i]), int'(m_dout[i]));
        else if (n > 0)    chk("dout_fwft", i, int'(dout[i]), int'(mq[i][0]));
      end
    end
  end

  // One edge with the given request; outputs are settled on return.
  task automatic op(input int i, input bit w, input bit r, input logic [7:0] d, input bit f);
    wr_en[i] = w; rd_en[i] = r; din[i] = d; flush[i] = f;
    @(posedge clk); #1;
    wr_en[i] = 1'b0; rd_en[i] = 1'b0; flush[i] = 1'b0;
  endtask

  // ---------------- directed stimulus with literal pins ----------------
  initial begin
    for (int i = 0; i < NI; i++) begin
      flush[i] = 0; din[i] = 0; wr_en[i] = 0; rd_en[i] = 0;
    end
    clear_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty",  0, int'(empty[0]), 1);
    chk("rst_aempty", 0, int'(aempty[0]), 1);
    chk("rst_dout",   0, int'(dout[0]), 0);
    clear_n = 1'b1;
    chk_en  = 1'b1;
    @(posedge clk); #1;

    // fill 16-deep
    for (int k = 0; k < 16; k++) begin
      op(0, 1, 0, 8'(k), 0);
      if (k == 13) chk("af_at14", 0, int'(afull[0]), 0);
      if (k == 14) begin
        chk("af_at15",   0, int'(afull[0]), 1);
        chk("full_at15", 0, int'(full[0]), 0);
      end
    end
    chk("full_at16", 0, int'(full[0]), 1);
    op(0, 1, 0, 8'hFF, 0);
    chk("wr_err_full", 0, int'(werr[0]), 1);
    chk("cnt_full",    0, dcnt[0], 16);

    // drain in order
    for (int k = 0; k < 16; k++) begin
      op(0, 0, 1, 8'h00, 0);
      chk("drain_ack",  0, int'(rack[0]), 1);
      chk("drain_data", 0, int'(dout[0]), k);
    end
    chk("drained_empty",  0, int'(empty[0]), 1);
    chk("drained_aempty", 0, int'(aempty[0]), 1);
    op(0, 0, 1, 8'h00, 0);
    chk("rd_err_empty", 0, int'(rerr[0]), 1);

    // simultaneous at empty: no bypass
    op(0, 1, 1, 8'h77, 0);
    chk("we_wack", 0, int'(wack[0]), 1);
    chk("we_rerr", 0, int'(rerr[0]), 1);
    chk("we_cnt",  0, dcnt[0], 1);
    // refill to full, then simultaneous at full
    for (int k = 1; k < 16; k++) op(0, 1, 0, 8'h40 + 8'(k), 0);
    op(0, 1, 1, 8'h55, 0);
    chk("wf_wack", 0, int'(wack[0]), 1);
    chk("wf_rack", 0, int'(rack[0]), 1);
    chk("wf_cnt",  0, dcnt[0], 16);
    chk("wf_full", 0, int'(full[0]), 1);
    chk("wf_dout", 0, int'(dout[0]), 8'h77);

    // depth 5: interleaved traffic across pointer wrap
    for (int k = 0; k < 12; k++) begin
      op(1, 1, k >= 3, 8'hA0 + 8'(k), 0);
      if (k >= 3) chk("d5_data", 1, int'(dout[1]), 8'hA0 + k - 3);
    end
    chk("d5_cnt3", 1, dcnt[1], 3);
    op(1, 1, 0, 8'hAC, 0);
    op(1, 1, 0, 8'hAD, 0);
    chk("d5_full", 1, int'(full[1]), 1);
    op(1, 1, 0, 8'hAE, 0);
    chk("d5_wr_err", 1, int'(werr[1]), 1);
    for (int k = 0; k < 5; k++) begin
      op(1, 0, 1, 8'h00, 0);
      chk("d5_drain", 1, int'(dout[1]), 8'hA9 + k);
    end

    // FWFT
    op(2, 1, 0, 8'h3C, 0);
    chk("fw_empty", 2, int'(empty[2]), 0);
    chk("fw_dout",  2, int'(dout[2]), 8'h3C);
    op(2, 0, 0, 8'h00, 0);
    chk("fw_hold",  2, int'(dout[2]), 8'h3C);
    op(2, 0, 1, 8'h00, 0);
    chk("fw_rack",  2, int'(rack[2]), 1);
    chk("fw_empt2", 2, int'(empty[2]), 1);
    op(2, 1, 0, 8'h11, 0);
    op(2, 1, 1, 8'h22, 0);
    chk("fw_c1_cnt",  2, dcnt[2], 1);
    chk("fw_c1_dout", 2, int'(dout[2]), 8'h22);
    op(2, 0, 1, 8'h00, 0);

    // flush with count 9, write ignored
    op(0, 1, 0, 8'h00, 1);
    for (int k = 0; k < 9; k++) op(0, 1, 0, 8'h90 + 8'(k), 0);
    chk("pre_flush_cnt", 0, dcnt[0], 9);
    op(0, 1, 0, 8'hEE, 1);
    chk("flush_cnt",   0, dcnt[0], 0);
    chk("flush_empty", 0, int'(empty[0]), 1);
    chk("flush_wack",  0, int'(wack[0]), 0);
    op(0, 1, 0, 8'h5A, 0);
    op(0, 0, 1, 8'h00, 0);
    chk("post_flush_data", 0, int'(dout[0]), 8'h5A);

    // async reset mid-cycle with count 9
    for (int k = 0; k < 9; k++) op(0, 1, 0, 8'hB0 + 8'(k), 0);
    #2;
    clear_n = 1'b0;
    #1;
    chk("arst_cnt",    0, dcnt[0], 0);
    chk("arst_empty",  0, int'(empty[0]), 1);
    chk("arst_aempty", 0, int'(aempty[0]), 1);
    chk("arst_full",   0, int'(full[0]), 0);
    chk("arst_afull",  0, int'(afull[0]), 0);
    chk("arst_dout",   0, int'(dout[0]), 0);
    @(negedge clk); #2;
    clear_n = 1'b1;
    @(posedge clk); #1;
    op(0, 1, 0, 8'hC5, 0);
    op(0, 0, 1, 8'h00, 0);
    chk("post_rst_data", 0, int'(dout[0]), 8'hC5);
    chk("post_rst_cnt",  0, dcnt[0], 0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, fully parametrised FIFO that succeeds the fixed 8x16 dual-clock FIFO wherever producer and consumer share one clock.
- Adds configurable width and depth (depth need not be a power of two).
- Adds programmable almost-full/almost-empty margins, an occupancy count, a synchronous flush, and a first-word-fall-through (FWFT) read mode.
- Keeps the existing wr_ack/wr_err/rd_ack/rd_err handshake so current testbench agents reuse unchanged.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 16, number of entries (>=2, any integer)
AF_MARGIN, 1, almost_full asserts when count >= DEPTH-AF_MARGIN (1..DEPTH-1)
AE_MARGIN, 1, almost_empty asserts when count <= AE_MARGIN (1..DEPTH-1)
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  single clock, all logic on rising edge
clear_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of contents/pointers, highest priority after reset
din  input  WIDTH  write data
wr_en  input  1  write request
rd_en  input  1  read request (pop in FWFT mode)
dout  output  WIDTH  read data
full  output  1  count == DEPTH
almost_full  output  1  count >= DEPTH-AF_MARGIN
empty  output  1  count == 0
almost_empty  output  1  count <= AE_MARGIN
count  output  $clog2(DEPTH+1)  current occupancy
wr_ack  output  1  write accepted on previous edge
wr_err  output  1  write rejected on previous edge
rd_ack  output  1  read accepted on previous edge
rd_err  output  1  read rejected on previous edge

Behaviour:
- Reset (clear_n=0, asynchronous):
  - wptr=rptr=count=0, dout=0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - All ack/err outputs 0. Memory contents are don't-care.
- flush=1 at an edge:
  - Same pointer, count and flag values as reset; dout holds.
  - Acks 0, errs 0; wr_en/rd_en are ignored that cycle.
- Write accept: wr_en && (!full || rd_accept).
  - Writing while full is allowed only with a concurrent accepted read.
  - Write: mem[wptr]<=din; wptr wraps DEPTH-1 -> 0 explicitly (no power-of-two assumption).
- Read accept: rd_en && !empty.
  - A read when empty is rejected even with a concurrent write; there is no empty bypass.
  - rptr wraps DEPTH-1 -> 0.
- count update: count+1 on write only, count-1 on read only, unchanged on both or neither.
  - Every flag is a registered function of the next count, so it is valid in the same cycle count changes.
- Handshake outputs are registered and valid one cycle after the request edge:
  - wr_ack=1 on accept; wr_err=1 on wr_en rejected.
  - rd_ack=1 on accept; rd_err=1 on rd_en rejected.
  - Both 0 for no request. ack and err are never both high.
- FWFT=0 (standard): dout <= mem[rptr] on read accept; new data valid in the rd_ack cycle. dout holds otherwise.
- FWFT=1:
  - dout = mem[rptr] combinationally whenever !empty; undefined-but-stable when empty.
  - A written word appears on dout the cycle after the write edge that clears empty.
  - rd_en pops the head; the next head appears after the edge.
- Simultaneous write and read with count==1 (FWFT=1): the head is popped and the new word becomes the head. count stays 1.

Decomposition:
- Shared package fifo_pkg holds:
  - function cnt_w(depth) returning $clog2(depth+1)
  - function ptr_w(depth) returning max(1,$clog2(depth))
  - localparam defaults WIDTH_DEF=8, DEPTH_DEF=16
  - typedef enum {STD, FWFT} rd_mode_e
- One sub-module, fifo_regfile: DEPTH x WIDTH register array with one synchronous write port and one combinational read port.
  - The top instantiates it and owns the pointers, count, flags and handshake.

Test Plan:
1. Reset, then fill: DEPTH=16, write 0x00..0x0F. almost_full rises when count goes 14->15; full rises on the 16th write. A 17th wr_en gives wr_err=1, count stays 16.
2. Drain with FWFT=0: read 16 times. dout shows 0x00..0x0F in order, each in its rd_ack cycle. Then empty=1, almost_empty=1, and a 17th rd_en gives rd_err=1.
3. Non-power-of-two wrap: DEPTH=5, 12 interleaved writes and reads of 0xA0+i. Data comes out in order across pointer wrap 4->0; count never exceeds 5.
4. Simultaneous access:
   - At full, wr_en+rd_en gives wr_ack=1, rd_ack=1, count stays 16, full stays 1.
   - At empty, wr_en+rd_en gives wr_ack=1, rd_err=1, count=1.
5. FWFT=1: write 0x3C into an empty FIFO. Next cycle empty=0 and dout=0x3C with no rd_en. rd_en then gives rd_ack=1 and empty=1.
6. Mid-operation clear: with count=9, pulse flush → count=0, empty=1, wr_en ignored that cycle. With count=9, drop clear_n between edges → all flags take reset values immediately. Next write/read returns the new data, not stale data.
